// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Low address bits that must be zero: fetches are word aligned, data is doubleword aligned
    localparam logic [2:0] I_ALIGN_MASK = 3'b011;
    localparam logic [2:0] D_ALIGN_MASK = 3'b111;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// rtl/mem_port_arbiter_prio.sv - D-favoured fixed priority with an instruction-fetch starvation guard
module arb_prio_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic d_valid,
    input  logic grant_en,
    output logic grant_i,
    output logic grant_d
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_i;

    always_comb begin
        force_i = i_valid && (starve_cnt == LIMIT);
        grant_d = grant_en && d_valid && !force_i;
        grant_i = grant_en && i_valid && !grant_d;
    end

    // Counts D wins that happened while a fetch was waiting; any gap in i_valid forgives them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_valid || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port 64-bit memory between fetch (I) and load/store (D)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 64,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [AW-1:0] i_addr,
    output logic          i_resp_valid,
    output logic [31:0]   i_resp_inst,
    output logic          i_err,
    input  logic          d_valid,
    output logic          d_ready,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [63:0]   d_wdata,
    input  logic [7:0]    d_wstrb,
    output logic          d_resp_valid,
    output logic [63:0]   d_resp_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-4:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wstrb,
    input  logic [63:0]   mem_rdata
);

    localparam int LW = $clog2(MEM_LAT + 1);

    state_t          state, state_n;
    logic            grant_en, grant_i, grant_d;
    logic            accept, misalign;
    logic [AW-1:2]   req_addr;
    logic            req_we;
    logic [63:0]     req_wdata;
    logic [7:0]      req_wstrb;
    logic            req_id;
    logic [LW-1:0]   lat_cnt;

    assign grant_en = rst_n && (state == IDLE);

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .d_valid  (d_valid),
        .grant_en (grant_en),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    assign i_ready  = grant_i;
    assign d_ready  = grant_d;
    // A grant is only ever given to a requester that is valid, so grant == accept
    assign accept   = grant_i || grant_d;
    assign misalign = grant_d ? |(d_addr[2:0] & D_ALIGN_MASK)
                              : |(i_addr[2:0] & I_ALIGN_MASK);

    assign mem_req      = (state == ISSUE);
    assign mem_we       = mem_req && req_we;
    assign mem_wstrb    = mem_we ? req_wstrb : 8'h00;
    assign mem_addr     = req_addr[AW-1:3];
    assign mem_wdata    = req_wdata;
    assign i_resp_valid = (state == RESP) && (req_id == REQ_I);
    assign d_resp_valid = (state == RESP) && (req_id == REQ_D);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = misalign ? RESP : ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (lat_cnt == LW'(1)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_we       <= 1'b0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            req_id       <= REQ_I;
            lat_cnt      <= '0;
            i_resp_inst  <= '0;
            i_err        <= 1'b0;
            d_resp_rdata <= '0;
            d_err        <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_id    <= grant_d ? REQ_D : REQ_I;
                        req_addr  <= grant_d ? d_addr[AW-1:2] : i_addr[AW-1:2];
                        req_we    <= grant_d && d_we;
                        req_wdata <= grant_d ? d_wdata : 64'h0;
                        req_wstrb <= grant_d ? d_wstrb : 8'h00;
                        // Misaligned requests skip memory; the error response is loaded now
                        if (misalign && grant_d) begin
                            d_err        <= 1'b1;
                            d_resp_rdata <= '0;
                        end else if (misalign) begin
                            i_err        <= 1'b1;
                            i_resp_inst  <= '0;
                        end
                    end
                end
                ISSUE: lat_cnt <= LW'(MEM_LAT);
                WAIT: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) begin
                        if (req_id == REQ_D) begin
                            d_resp_rdata <= req_we ? 64'h0 : mem_rdata;
                            d_err        <= 1'b0;
                        end else begin
                            i_resp_inst  <= req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                            i_err        <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int LIM  = 4;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
    localparam logic [63:0] RD_IDLE = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        exp_err;
        logic [63:0] exp_data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst_n, ram_clr;
    logic i_valid, d_valid, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wstrb;
    logic i_ready, d_ready, i_resp_valid, i_err, d_resp_valid, d_err, mem_req, mem_we;
    logic [31:0] i_resp_inst;
    logic [63:0] d_resp_rdata, mem_wdata, mem_rdata;
    logic [AW-4:0] mem_addr;
    logic [7:0] mem_wstrb;

    logic b_i_valid, b_d_valid, b_d_we;
    logic [AW-1:0] b_i_addr, b_d_addr;
    logic [63:0] b_d_wdata;
    logic [7:0]  b_d_wstrb;
    logic b_i_ready, b_d_ready, b_i_resp_valid, b_i_err, b_d_resp_valid, b_d_err, b_mem_req, b_mem_we;
    logic [31:0] b_i_resp_inst;
    logic [63:0] b_d_resp_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-4:0] b_mem_addr;
    logic [7:0] b_mem_wstrb;

    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT1), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_resp_inst(i_resp_inst), .i_err(i_err),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT3), .STARVE_LIMIT(LIM)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_addr(b_i_addr),
        .i_resp_valid(b_i_resp_valid), .i_resp_inst(b_i_resp_inst), .i_err(b_i_err),
        .d_valid(b_d_valid), .d_ready(b_d_ready), .d_we(b_d_we), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb),
        .d_resp_valid(b_d_resp_valid), .d_resp_rdata(b_d_resp_rdata), .d_err(b_d_err),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [63:0] init_word(input int k);
        return {32'h0100_0000 + 32'(k), 32'h0200_0000 + 32'(k)};
    endfunction

    // Synchronous memories: read data appears MEM_LAT cycles after the strobe, garbage otherwise
    logic [63:0] ram [64];
    logic [63:0] rdq;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < 8; b++)
                if (mem_wstrb[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        rdq <= mem_req ? ram[mem_addr[5:0]] : RD_IDLE;
    end
    assign mem_rdata = rdq;

    logic [63:0] b_ram [64];
    logic [63:0] b_q [LAT3];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int k = 0; k < 64; k++) b_ram[k] <= init_word(k);
        end else if (b_mem_req && b_mem_we) begin
            for (int b = 0; b < 8; b++)
                if (b_mem_wstrb[b]) b_ram[b_mem_addr[5:0]][b*8 +: 8] <= b_mem_wdata[b*8 +: 8];
        end
        b_q[0] <= b_mem_req ? b_ram[b_mem_addr[5:0]] : RD_IDLE;
        for (int s = 1; s < LAT3; s++) b_q[s] <= b_q[s-1];
    end
    assign b_mem_rdata = b_q[LAT3-1];

    // Transaction-level reference: a plain array of doublewords
    logic [63:0] ref_mem [64];

    function automatic void ref_apply(input txn_t v, output logic [63:0] ed, output logic ee);
        int w;
        w = int'(v.addr[8:3]);
        ed = 64'h0;
        if (v.is_d) begin
            ee = (v.addr[2:0] != 3'b000);
            if (!ee && v.we) begin
                for (int b = 0; b < 8; b++)
                    if (v.wstrb[b]) ref_mem[w][b*8 +: 8] = v.wdata[b*8 +: 8];
            end else if (!ee) begin
                ed = ref_mem[w];
            end
        end else begin
            ee = (v.addr[1:0] != 2'b00);
            if (!ee) ed = v.addr[2] ? {32'h0, ref_mem[w][63:32]} : {32'h0, ref_mem[w][31:0]};
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic run_txn(input txn_t v, output logic [63:0] rd, output logic er, output int lat,
                           output int nreq, output logic [60:0] ma, output logic mw, output int stray);
        int t;
        rd = '0; er = 1'b0; lat = 0; nreq = 0; ma = '0; mw = 1'b0; stray = 0;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_valid = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_valid = 1'b1; i_addr = v.addr;
        end
        #1;
        t = 0;
        while (!(v.is_d ? d_ready : i_ready) && t < 20) begin
            @(posedge clk); #2; t++;
        end
        @(posedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0;
        #1;
        if (t >= 20) begin
            lat = -1;
            return;
        end
        lat = 1;
        while (lat < 20) begin
            if (i_ready || d_ready) stray++;
            if (mem_req) begin nreq++; ma = mem_addr; mw = mem_we; end
            if (v.is_d ? i_resp_valid : d_resp_valid) stray++;
            if (v.is_d ? d_resp_valid : i_resp_valid) begin
                rd = v.is_d ? d_resp_rdata : {32'h0, i_resp_inst};
                er = v.is_d ? d_err : i_err;
                break;
            end
            @(posedge clk); #2; lat++;
        end
    endtask

    task automatic check_txn(input txn_t v, input string nm);
        logic [63:0] rd; logic er; int lat, nreq, stray; logic [60:0] ma; logic mw;
        run_txn(v, rd, er, lat, nreq, ma, mw, stray);
        chk({nm, "_err"}, 64'(er), 64'(v.exp_err));
        if (!v.exp_err) chk({nm, "_data"}, rd, v.exp_data);
        chk({nm, "_lat"}, 64'(lat), v.exp_err ? 64'd1 : 64'(LAT1 + 2));
        chk({nm, "_nreq"}, 64'(nreq), v.exp_err ? 64'd0 : 64'd1);
        if (!v.exp_err) begin
            chk({nm, "_maddr"}, 64'(ma), 64'(v.addr[63:3]));
            chk({nm, "_mwe"}, 64'(mw), 64'(v.is_d && v.we));
        end
        chk({nm, "_stray"}, 64'(stray), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1);
    end

    initial begin
        txn_t vec [12];
        txn_t v;
        logic [63:0] ed;
        logic ee;
        logic order [10];
        int n, t, both, pulses;

        rst_n = 1'b0; ram_clr = 1'b1;
        i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        b_i_valid = 1'b0; b_d_valid = 1'b0; b_d_we = 1'b0; b_i_addr = '0; b_d_addr = '0;
        b_d_wdata = '0; b_d_wstrb = '0;
        for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);

        //            is_d  we    addr      wdata                   wstrb  err   exp_data
        vec[0]  = '{1'b1, 1'b1, 64'h00, 64'h00400393_002083B3, 8'hFF, 1'b0, 64'h0};
        vec[1]  = '{1'b0, 1'b0, 64'h04, 64'h0,                 8'h00, 1'b0, 64'h00400393};
        vec[2]  = '{1'b0, 1'b0, 64'h00, 64'h0,                 8'h00, 1'b0, 64'h002083B3};
        vec[3]  = '{1'b1, 1'b1, 64'h10, 64'h1E,                8'hFF, 1'b0, 64'h0};
        vec[4]  = '{1'b1, 1'b0, 64'h10, 64'h0,                 8'h00, 1'b0, 64'h1E};
        vec[5]  = '{1'b1, 1'b0, 64'h12, 64'h0,                 8'h00, 1'b1, 64'h0};
        vec[6]  = '{1'b0, 1'b0, 64'h02, 64'h0,                 8'h00, 1'b1, 64'h0};
        vec[7]  = '{1'b1, 1'b1, 64'h18, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 1'b0, 64'h0};
        vec[8]  = '{1'b1, 1'b0, 64'h18, 64'h0,                 8'h00, 1'b0, 64'h01000003_FFFFFFFF};
        vec[9]  = '{1'b0, 1'b0, 64'h1C, 64'h0,                 8'h00, 1'b0, 64'h01000003};
        vec[10] = '{1'b1, 1'b1, 64'h21, 64'hDEAD,              8'hFF, 1'b1, 64'h0};
        vec[11] = '{1'b1, 1'b0, 64'h20, 64'h0,                 8'h00, 1'b0, 64'h01000004_02000004};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ctrl", 64'({i_ready, d_ready, i_resp_valid, i_err, d_resp_valid, d_err, mem_req, mem_we}), 64'h0);
        chk("rst_data", 64'({mem_wstrb, i_resp_inst}), 64'h0);
        chk("rst_drdata", d_resp_rdata, 64'h0);
        chk("rst_maddr", 64'(mem_addr), 64'h0);
        chk("rst_mwdata", mem_wdata, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; ram_clr = 1'b0;

        for (int k = 0; k < 12; k++) begin
            ref_apply(vec[k], ed, ee);
            check_txn(vec[k], $sformatf("vec%0d", k));
        end

        // Both requesters held: D wins LIM times in a row, then I is forced through
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 64'h8; d_valid = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        #1;
        n = 0; t = 0; both = 0;
        while (n < 10 && t < 300) begin
            if (i_ready && d_ready) both++;
            if (i_ready || d_ready) begin
                order[n] = d_ready;
                n++;
            end
            @(posedge clk); #2; t++;
        end
        @(posedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0;
        repeat (6) @(posedge clk);
        chk("starve_count", 64'(n), 64'd10);
        chk("starve_both", 64'(both), 64'd0);
        for (int k = 0; k < n; k++)
            chk($sformatf("starve_g%0d_is_d", k), 64'(order[k]), 64'((k % (LIM + 1)) != LIM));

        // Reset while the load sits in WAIT: the response must never appear
        @(posedge clk); #1;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        #1;
        chk("rw_accept", 64'(d_ready), 64'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        #1;
        chk("rw_issue", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("rw_in_reset", 64'({mem_req, d_resp_valid, i_resp_valid, d_ready, i_ready}), 64'h0);
        chk("rw_rdata", d_resp_rdata, 64'h0);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #2;
            if (d_resp_valid || i_resp_valid || mem_req) pulses++;
        end
        chk("rw_no_pulse", 64'(pulses), 64'd0);
        v = '{1'b0, 1'b0, 64'h04, 64'h0, 8'h00, 1'b0, 64'h0};
        ref_apply(v, ed, ee);
        v.exp_data = ed; v.exp_err = ee;
        check_txn(v, "rw_fetch");

        // Three-cycle memory: request held so the next accept shows the earliest re-grant
        @(posedge clk); #1;
        b_d_valid = 1'b1; b_d_addr = 64'h8;
        #1;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("lat3_c%0d", c),
                64'({b_d_ready, b_mem_req, b_d_resp_valid, b_i_ready, b_i_resp_valid}),
                64'({(c == 0 || c == LAT3 + 3), (c == 1), (c == LAT3 + 2), 1'b0, 1'b0}));
            if (c == 1) chk("lat3_maddr", 64'(b_mem_addr), 64'd1);
            if (c == LAT3 + 2) chk("lat3_rdata", b_d_resp_rdata, init_word(1));
            @(posedge clk); #2;
        end
        b_d_valid = 1'b0;
        repeat (8) @(posedge clk);

        for (int k = 0; k < 80; k++) begin
            v.is_d  = 1'($urandom_range(0, 1));
            v.we    = v.is_d & 1'($urandom_range(0, 1));
            v.addr  = 64'($urandom_range(0, 63)) << 3;
            if ($urandom_range(0, 7) == 0) v.addr[2:0] = 3'($urandom_range(1, 7));
            else if (!v.is_d) v.addr[2] = 1'($urandom_range(0, 1));
            v.wdata = {$urandom, $urandom};
            v.wstrb = 8'($urandom);
            ref_apply(v, ed, ee);
            v.exp_data = ed; v.exp_err = ee;
            check_txn(v, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
